// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: issues word loads/stores over a
// req/ack handshake, stalls upstream while waiting, and registers the writeback fields.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_mem_i,
  input  logic        rf_en_mem_i,
  input  logic [1:0]  wb_sel_mem_i,
  input  logic        mem_wr_mem_i,
  input  logic        is_lw_mem_i,
  input  logic [4:0]  rd_mem_i,
  input  logic [31:0] alu_res_mem_i,
  input  logic [31:0] next_seq_pc_mem_i,
  input  logic [31:0] r_data_p2_mem_i,
  output logic        dmem_req_o,
  output logic        dmem_wr_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_mem_o,
  output logic        valid_wb_o,
  output logic        rf_en_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [31:0] wr_data_wb_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        valid_wb_q, valid_wb_d;
  logic        rf_en_wb_q, rf_en_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [31:0] wr_data_wb_q, wr_data_wb_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic mem_op, aligned, req, stall, misalign_now, timeout_now, fault;
  logic [31:0] wb_data;

  assign mem_op  = valid_mem_i & (is_lw_mem_i | mem_wr_mem_i);
  assign aligned = (alu_res_mem_i[1:0] == 2'b00);

  // Handshake FSM: an aligned access that is not acked in its first cycle waits here.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    req          = 1'b0;
    stall        = 1'b0;
    misalign_now = 1'b0;
    timeout_now  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op && aligned) begin
          req = 1'b1;
          if (!dmem_ack_i) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end else if (mem_op) begin
          misalign_now = 1'b1;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (dmem_ack_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_now = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A mid-access reset must drop the handshake outputs in the same cycle.
    if (reset) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign fault = misalign_now | timeout_now;

  always_comb begin
    unique case (wb_sel_mem_i)
      2'b00:   wb_data = alu_res_mem_i;
      2'b01:   wb_data = dmem_rdata_i;
      2'b10:   wb_data = next_seq_pc_mem_i;
      default: wb_data = 32'h0;
    endcase
  end

  always_comb begin
    valid_wb_d   = 1'b0;
    rf_en_wb_d   = 1'b0;
    rd_wb_d      = '0;
    wr_data_wb_d = '0;
    misalign_d   = misalign_now;
    bus_err_d    = timeout_now;
    if (!stall) begin
      valid_wb_d   = valid_mem_i & ~fault;
      rf_en_wb_d   = valid_mem_i & ~fault & rf_en_mem_i & (rd_mem_i != 5'd0);
      rd_wb_d      = rd_mem_i;
      wr_data_wb_d = wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      valid_wb_q   <= 1'b0;
      rf_en_wb_q   <= 1'b0;
      rd_wb_q      <= '0;
      wr_data_wb_q <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_wb_q   <= valid_wb_d;
      rf_en_wb_q   <= rf_en_wb_d;
      rd_wb_q      <= rd_wb_d;
      wr_data_wb_q <= wr_data_wb_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req_o   = req;
  assign dmem_wr_o    = mem_wr_mem_i;
  assign dmem_addr_o  = alu_res_mem_i;
  assign dmem_wdata_o = r_data_p2_mem_i;
  assign stall_mem_o  = stall;
  assign valid_wb_o   = valid_wb_q;
  assign rf_en_wb_o   = rf_en_wb_q;
  assign rd_wb_o      = rd_wb_q;
  assign wr_data_wb_o = wr_data_wb_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver applies instructions and a memory
// responder, pushes expected writebacks; a monitor pops and compares them.
module tb_mem_access_stage;

  localparam int T = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_mem_i, rf_en_mem_i, mem_wr_mem_i, is_lw_mem_i;
  logic [1:0]  wb_sel_mem_i;
  logic [4:0]  rd_mem_i;
  logic [31:0] alu_res_mem_i, next_seq_pc_mem_i, r_data_p2_mem_i;
  logic        dmem_req_o, dmem_wr_o, dmem_ack_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        stall_mem_o, valid_wb_o, rf_en_wb_o, misalign_o, bus_err_o;
  logic [4:0]  rd_wb_o;
  logic [31:0] wr_data_wb_o;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_mem_i       (valid_mem_i),
    .rf_en_mem_i       (rf_en_mem_i),
    .wb_sel_mem_i      (wb_sel_mem_i),
    .mem_wr_mem_i      (mem_wr_mem_i),
    .is_lw_mem_i       (is_lw_mem_i),
    .rd_mem_i          (rd_mem_i),
    .alu_res_mem_i     (alu_res_mem_i),
    .next_seq_pc_mem_i (next_seq_pc_mem_i),
    .r_data_p2_mem_i   (r_data_p2_mem_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_wr_o         (dmem_wr_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .stall_mem_o       (stall_mem_o),
    .valid_wb_o        (valid_wb_o),
    .rf_en_wb_o        (rf_en_wb_o),
    .rd_wb_o           (rd_wb_o),
    .wr_data_wb_o      (wr_data_wb_o),
    .misalign_o        (misalign_o),
    .bus_err_o         (bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        rf_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        misalign;
    logic        bus_err;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any writeback event (valid, misalign or bus error) consumes one expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && (valid_wb_o || misalign_o || bus_err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wb", {valid_wb_o, misalign_o, bus_err_o}, 3'b000);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_valid", valid_wb_o, e.valid);
        check("wb_rf_en", rf_en_wb_o, e.rf_en);
        check("wb_misalign", misalign_o, e.misalign);
        check("wb_bus_err", bus_err_o, e.bus_err);
        if (e.valid) begin
          check("wb_rd", rd_wb_o, e.rd);
          check("wb_data", wr_data_wb_o, e.data);
        end
      end
    end
  end

  // One instruction; the responder acks in request cycle `lat` (>T means never).
  task automatic issue(input logic v, input logic lw, input logic wr, input logic rfen,
                       input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int lat);
    bit  mem_op, al, req_path, timed_out, exp_stall, done;
    wb_t e;
    int  i;
    mem_op    = v && (lw || wr);
    al        = (alu % 4) == 0;
    req_path  = mem_op && al;
    timed_out = req_path && lat > T;
    done      = 0;
    i         = 0;
    while (!done) begin
      @(posedge clk); #1;
      valid_mem_i       = v;
      is_lw_mem_i       = lw;
      mem_wr_mem_i      = wr;
      rf_en_mem_i       = rfen;
      wb_sel_mem_i      = sel;
      rd_mem_i          = rd;
      alu_res_mem_i     = alu;
      next_seq_pc_mem_i = pc;
      r_data_p2_mem_i   = sdata;
      dmem_ack_i        = req_path ? (i == lat) : 1'($urandom_range(0, 1));
      dmem_rdata_i      = (req_path && i == lat) ? rdata : $urandom;
      @(negedge clk);
      exp_stall = req_path && i < lat && i < T;
      check("dmem_req", dmem_req_o, req_path);
      check("stall", stall_mem_o, exp_stall);
      if (req_path) check("dmem_bus", {dmem_addr_o, dmem_wdata_o, dmem_wr_o}, {alu, sdata, wr});
      if (!exp_stall) done = 1;
      i++;
    end
    if (v) begin
      e = '0;
      if (mem_op && !al) begin
        e.misalign = 1'b1;
      end else if (timed_out) begin
        e.bus_err = 1'b1;
      end else begin
        e.valid = 1'b1;
        e.rf_en = rfen && rd != 0;
        e.rd    = rd;
        e.data  = (sel == 2'd0) ? alu : (sel == 2'd1) ? rdata : (sel == 2'd2) ? pc : 32'd0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      valid_mem_i = 1'b0;
      dmem_ack_i  = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid_mem_i = 0; rf_en_mem_i = 0; mem_wr_mem_i = 0; is_lw_mem_i = 0;
    wb_sel_mem_i = 0; rd_mem_i = 0; alu_res_mem_i = 0; next_seq_pc_mem_i = 0;
    r_data_p2_mem_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {valid_wb_o, rf_en_wb_o, rd_wb_o, wr_data_wb_o, misalign_o, bus_err_o}, '0);
    check("reset_req_stall", {dmem_req_o, stall_mem_o}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    issue(1, 1, 0, 1, 2'b01, 5'd5, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 0);
    issue(1, 0, 1, 0, 2'b00, 5'd0, 32'h204, 32'h8, 32'h12345678, 32'h0, 3);
    issue(1, 1, 0, 1, 2'b01, 5'd7, 32'h300, 32'hC, 32'h0, 32'h0, NEVER);
    issue(1, 0, 0, 1, 2'b00, 5'd9, 32'h55, 32'h10, 32'h0, 32'h0, 0);
    issue(1, 1, 0, 1, 2'b01, 5'd6, 32'h102, 32'h14, 32'h0, 32'h0, 0);
    issue(1, 0, 0, 1, 2'b00, 5'd0, 32'h77, 32'h18, 32'h0, 32'h0, 0);
    issue(1, 0, 0, 1, 2'b10, 5'd1, 32'h99, 32'h40, 32'h0, 32'h0, 0);
    issue(1, 1, 0, 1, 2'b01, 5'd3, 32'h400, 32'h1C, 32'h0, 32'hCAFEF00D, T);
    issue(1, 1, 1, 0, 2'b00, 5'd4, 32'h408, 32'h20, 32'hA5A5A5A5, 32'h0, 1);

    // Reset arriving on the second wait cycle of a load
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      valid_mem_i = 1; is_lw_mem_i = 1; mem_wr_mem_i = 0; rf_en_mem_i = 1;
      wb_sel_mem_i = 2'b01; rd_mem_i = 5'd8; alu_res_mem_i = 32'h500; dmem_ack_i = 0;
      if (i == 2) reset = 1'b1;
    end
    @(negedge clk);
    check("rst_wait_req_stall", {dmem_req_o, stall_mem_o}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0; valid_mem_i = 0; dmem_ack_i = 1; dmem_rdata_i = 32'h13579BDF;
    @(negedge clk);
    check("rst_wait_outputs", {valid_wb_o, rf_en_wb_o, rd_wb_o, wr_data_wb_o, misalign_o, bus_err_o}, '0);
    check("late_ack_req_stall", {dmem_req_o, stall_mem_o}, 2'b00);
    issue(1, 1, 0, 1, 2'b01, 5'd10, 32'h600, 32'h24, 32'h0, 32'h2468ACE0, 1);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind, r, lat;
      logic lw, wr, v;
      logic [1:0]  sel;
      logic [31:0] addr;
      kind = $urandom_range(0, 3);
      v    = ($urandom_range(0, 9) != 0);
      lw   = (kind == 0 || kind == 2);
      wr   = (kind == 1 || kind == 2);
      if (lw && !wr) sel = 2'($urandom_range(0, 3));
      else begin
        r   = $urandom_range(0, 2);
        sel = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
      end
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
      r   = $urandom_range(0, 9);
      lat = (r <= 4) ? r : (r <= 6) ? NEVER : 0;
      issue(v, lw, wr, 1'($urandom_range(0, 1)), sel, 5'($urandom_range(0, 31)), addr,
            $urandom, $urandom, $urandom, lat);
      if ($urandom_range(0, 9) == 0) idle(1);
    end

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
